// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port among
//               NREQ producers, with bursts bounded by MAX_BURST words.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ-1:0]      req_last,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [2:0]           owner,
    output logic                 busy,
    output logic                 fifo_wr,
    output logic [DW-1:0]        fifo_data_in,
    input  logic                 fifo_full,
    input  logic [3:0]           fifo_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0] c_nreq      = 4'(NREQ);
    localparam logic [3:0] c_last_beat = 4'(MAX_BURST - 1);
    localparam logic [2:0] c_init_last = 3'(NREQ - 1);

    state_t            r_state;
    logic [2:0]        r_owner;
    logic [2:0]        r_last_owner;
    logic [3:0]        r_beat_cnt;
    logic [NREQ-1:0]   r_gnt;

    state_t            w_state_nxt;
    logic [2:0]        w_owner_nxt;
    logic [2:0]        w_last_nxt;
    logic [3:0]        w_beat_nxt;
    logic [NREQ-1:0]   w_gnt_nxt;

    logic              w_own_req;
    logic              w_own_last;
    logic [DW-1:0]     w_own_data;
    logic              w_acc;
    logic              w_pick_valid;
    logic [2:0]        w_pick;
    logic [NREQ-1:0]   w_pick_oh;
    logic [3:0]        w_cand;
    logic              w_unused_cnt;

    // Occupancy is informational only; the arbiter reacts to full alone.
    assign w_unused_cnt = ^fifo_cnt;

    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == 3'(i)) begin
                w_own_req  = req[i];
                w_own_last = req_last[i];
                w_own_data = req_data[i*DW +: DW];
            end
        end
    end

    // Scan upward from the previous owner so it has the lowest priority.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = '0;
        w_pick_oh    = '0;
        w_cand       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand = {1'b0, r_last_owner} + 4'(k);
            if (w_cand >= c_nreq) begin
                w_cand = w_cand - c_nreq;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!w_pick_valid && (w_cand == 4'(j)) && req[j]) begin
                    w_pick_valid = 1'b1;
                    w_pick       = 3'(j);
                    w_pick_oh    = '0;
                    w_pick_oh[j] = 1'b1;
                end
            end
        end
    end

    assign busy         = (r_state == ST_GRANT);
    assign w_acc        = busy & w_own_req & ~fifo_full;
    assign fifo_wr      = w_acc & ~rst;
    assign fifo_data_in = busy ? w_own_data : '0;
    assign gnt          = r_gnt;
    assign owner        = r_owner;

    always_comb begin
        ack = '0;
        for (int i = 0; i < NREQ; i++) begin
            ack[i] = fifo_wr & (r_owner == 3'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        w_beat_nxt  = r_beat_cnt;
        w_gnt_nxt   = r_gnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_state_nxt = ST_GRANT;
                    w_owner_nxt = w_pick;
                    w_gnt_nxt   = w_pick_oh;
                    w_beat_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (w_acc) begin
                    w_beat_nxt = r_beat_cnt + 4'd1;
                end
                if (!w_own_req || (w_acc && (w_own_last || (r_beat_cnt == c_last_beat)))) begin
                    w_state_nxt = ST_IDLE;
                    w_owner_nxt = '0;
                    w_gnt_nxt   = '0;
                    w_last_nxt  = r_owner;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= c_init_last;
            r_beat_cnt   <= '0;
            r_gnt        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_beat_cnt   <= w_beat_nxt;
            r_gnt        <= w_gnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Scoreboard bench for fifo_wr_arbiter with a transaction-level
//               reference model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 8;
    localparam int MAX_BURST = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     gnt;
    logic [NREQ-1:0]     ack;
    logic [2:0]          owner;
    logic                busy;
    logic                fifo_wr;
    logic [DW-1:0]       fifo_data_in;
    logic                fifo_full;
    logic [3:0]          fifo_cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .gnt(gnt), .ack(ack), .owner(owner), .busy(busy), .fifo_wr(fifo_wr),
        .fifo_data_in(fifo_data_in), .fifo_full(fifo_full), .fifo_cnt(fifo_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Each producer holds a list of {last, data} words it still has to send.
    logic [DW:0]     prod_q [NREQ][$];
    logic [NREQ-1:0] hold;
    logic [DW+2:0]   sb_q [$];

    // Reference model: who holds the grant, who finished last, words so far.
    bit m_busy  = 1'b0;
    int m_owner = 0;
    int m_last  = NREQ - 1;
    int m_beats = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input int r, input logic [DW-1:0] d, input logic l);
        prod_q[r].push_back({l, d});
    endtask

    task automatic drive_inputs();
        logic [DW:0] w;
        for (int i = 0; i < NREQ; i++) begin
            if (prod_q[i].size() > 0) begin
                w = prod_q[i][0];
                req[i]                = ~hold[i];
                req_data[i*DW +: DW]  = w[DW-1:0];
                req_last[i]           = w[DW];
            end else begin
                req[i]                = 1'b0;
                req_data[i*DW +: DW]  = DW'($urandom);
                req_last[i]           = 1'($urandom);
            end
        end
        fifo_cnt = 4'($urandom);
    endtask

    task automatic cycle();
        logic [NREQ-1:0] e_gnt;
        logic [NREQ-1:0] e_ack;
        logic [DW-1:0]   e_data;
        bit              acc;
        bit              e_wr;
        drive_inputs();
        @(negedge clk);
        e_gnt  = '0;
        e_ack  = '0;
        e_data = '0;
        acc    = 1'b0;
        e_wr   = 1'b0;
        if (m_busy) begin
            e_gnt  = NREQ'(1) << m_owner;
            e_data = req_data[m_owner*DW +: DW];
            acc    = req[m_owner] && !fifo_full;
            e_wr   = acc && !rst;
            if (e_wr) e_ack = NREQ'(1) << m_owner;
        end
        check("gnt", gnt, e_gnt);
        check("busy", busy, m_busy);
        check("owner", owner, m_busy ? m_owner : 0);
        check("fifo_wr", fifo_wr, e_wr);
        check("ack", ack, e_ack);
        check("fifo_data_in", fifo_data_in, e_data);
        if (e_wr) sb_q.push_back({3'(m_owner), e_data});
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i] === 1'b1 && prod_q[i].size() > 0) prod_q[i].delete(0);
        end
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_last = NREQ - 1; m_beats = 0;
        end else if (m_busy) begin
            if (!req[m_owner] || (acc && (req_last[m_owner] || m_beats == MAX_BURST - 1))) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end else if (acc) begin
                m_beats++;
            end
        end else if (req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (req[(m_last + k) % NREQ]) begin
                    m_owner = (m_last + k) % NREQ;
                    break;
                end
            end
            m_busy  = 1'b1;
            m_beats = 0;
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write the DUT presents must match the oldest prediction.
    initial begin
        logic [DW+2:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (fifo_wr === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_write: got unexpected write of %0h, required no write at %0t",
                             fifo_data_in, $time);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_data", fifo_data_in, e[DW-1:0]);
                    check("sb_ack", ack, NREQ'(1) << e[DW+2:DW]);
                end
            end
        end
    end

    initial begin
        int  guard;
        bit  pending;
        rst       = 1'b1;
        fifo_full = 1'b0;
        hold      = '0;
        req       = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_cnt  = '0;
        repeat (3) cycle();
        rst = 1'b0;

        // Single burst from requester 1.
        push_word(1, 8'd42, 1'b0);
        push_word(1, 8'd30, 1'b0);
        push_word(1, 8'd55, 1'b1);
        repeat (6) cycle();

        // Two contenders with single-word bursts alternate.
        for (int n = 0; n < 2; n++) begin
            push_word(0, DW'($urandom), 1'b1);
            push_word(2, DW'($urandom), 1'b1);
        end
        repeat (10) cycle();

        // Six words with no last marker: truncated after MAX_BURST.
        for (int n = 0; n < 6; n++) push_word(3, DW'(100 + n), 1'b0);
        repeat (12) cycle();

        // Full stall in the middle of a burst.
        push_word(0, 8'd86, 1'b0);
        push_word(0, 8'd87, 1'b0);
        push_word(0, 8'd88, 1'b1);
        repeat (2) cycle();
        fifo_full = 1'b1;
        repeat (5) cycle();
        fifo_full = 1'b0;
        repeat (4) cycle();

        // Owner withdraws after one word while another requester waits.
        for (int n = 0; n < 3; n++) push_word(1, DW'(20 + n), n == 2);
        push_word(2, 8'd77, 1'b1);
        repeat (2) cycle();
        hold[1] = 1'b1;
        repeat (4) cycle();
        hold[1] = 1'b0;
        repeat (10) cycle();

        // Reset lands on the second word of a burst.
        push_word(2, 8'd10, 1'b0);
        push_word(2, 8'd11, 1'b0);
        push_word(2, 8'd12, 1'b1);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        push_word(0, 8'd5, 1'b1);
        push_word(3, 8'd6, 1'b1);
        repeat (12) cycle();

        // Random traffic with stalls and withdrawals.
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (prod_q[i].size() < 3 && $urandom_range(0, 3) == 0)
                    push_word(i, DW'($urandom), $urandom_range(0, 2) == 0);
                hold[i] = ($urandom_range(0, 15) == 0);
            end
            fifo_full = ($urandom_range(0, 4) == 0);
            cycle();
        end

        // Drain every producer, bounded.
        hold      = '0;
        fifo_full = 1'b0;
        guard     = 0;
        pending   = 1'b1;
        while (pending && guard < 300) begin
            cycle();
            guard++;
            pending = busy;
            for (int i = 0; i < NREQ; i++) if (prod_q[i].size() > 0) pending = 1'b1;
        end
        check("drain_timeout", 32'(pending), 32'd0);
        repeat (3) cycle();
        check("sb_leftover", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
